// File: rtl/instr_queue_param_pkg.sv
// Shared decode/dispatch types: default field widths, the NOP opcode and the
// instruction record that the queue, RS and ROB exchange.
package viola_pkg;

    localparam int OP_W_DEF  = 5;
    localparam int REG_W_DEF = 5;
    localparam int IMM_W_DEF = 32;

    localparam logic [OP_W_DEF-1:0] NOP_OP = 5'b11111;

    typedef struct packed {
        logic [OP_W_DEF-1:0]  op;
        logic [REG_W_DEF-1:0] rs1;
        logic [REG_W_DEF-1:0] rs2;
        logic [REG_W_DEF-1:0] rd;
        logic [IMM_W_DEF-1:0] imm;
        logic                 has_imm;
    } instr_t;

endpackage

// File: rtl/instr_queue_param_if.sv
// Decoder-to-issue bundle for the instruction queue: decoded instruction in,
// backpressure and status, dispatched instruction out.
interface instr_queue_param_if
    import viola_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int OP_W  = OP_W_DEF,
    parameter int REG_W = REG_W_DEF,
    parameter int IMM_W = IMM_W_DEF
) ();
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic [IMM_W-1:0] imm;
    logic             has_imm;
    logic             flush;
    logic             rs_full;
    logic             rob_full;

    logic             iq_full;
    logic             iq_afull;
    logic [CNT_W-1:0] count;
    logic             shooted;
    logic [OP_W-1:0]  op_out;
    logic [REG_W-1:0] rs1_out;
    logic [REG_W-1:0] rs2_out;
    logic [REG_W-1:0] rd_out;
    logic [IMM_W-1:0] imm_out;
    logic             has_imm_out;

    modport master (
        output op, rs1, rs2, rd, imm, has_imm, flush, rs_full, rob_full,
        input  iq_full, iq_afull, count, shooted,
               op_out, rs1_out, rs2_out, rd_out, imm_out, has_imm_out
    );

    modport slave (
        input  op, rs1, rs2, rd, imm, has_imm, flush, rs_full, rob_full,
        output iq_full, iq_afull, count, shooted,
               op_out, rs1_out, rs2_out, rd_out, imm_out, has_imm_out
    );

endinterface

// File: rtl/instr_queue_param_ring_buffer.sv
// Generic DEPTH x WIDTH circular buffer; pointers wrap at DEPTH-1 so DEPTH need
// not be a power of two. Callers must not push when full or pop when empty.
module iq_ring_buffer #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clr) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = wrap_inc(tail_q);
            if (pop)  head_d = wrap_inc(head_q);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; head/tail/count alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push && !clr && !rst) mem[tail_q] <= wdata;
    end

    assign rdata = mem[head_q];
    assign count = count_q;
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/instr_queue_param.sv
// In-order instruction queue between decoder and RS/ROB dispatch: NOP decode,
// dispatch gating, branch flush and registered dispatch outputs around a ring buffer.
module instr_queue_param
    import viola_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int OP_W         = OP_W_DEF,
    parameter int REG_W        = REG_W_DEF,
    parameter int IMM_W        = IMM_W_DEF,
    parameter int AFULL_MARGIN = 2
) (
    input  logic                clk,
    input  logic                rst,
    instr_queue_param_if.slave  bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = OP_W + 3 * REG_W + IMM_W + 1;
    localparam logic [OP_W-1:0] NOP = {OP_W{1'b1}};

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic [IMM_W-1:0] imm;
        logic             has_imm;
    } entry_t;

    localparam entry_t OUT_RST = entry_t'({NOP, {(ENT_W - OP_W){1'b0}}});

    entry_t           wr_entry, rd_entry;
    entry_t           out_q, out_d;
    logic             shooted_q, shooted_d;
    logic             enq, deq;
    logic             rb_full, rb_empty;
    logic [CNT_W-1:0] rb_count;

    assign wr_entry = {bus.op, bus.rs1, bus.rs2, bus.rd, bus.imm, bus.has_imm};

    // Full blocks enqueue even when a dequeue frees a slot in the same cycle.
    assign enq = (bus.op != NOP) && !rb_full && !bus.flush && !rst;
    assign deq = !rb_empty && !bus.rs_full && !bus.rob_full && !bus.flush && !rst;

    iq_ring_buffer #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_ring (
        .clk   (clk),
        .rst   (rst),
        .clr   (bus.flush),
        .push  (enq),
        .pop   (deq),
        .wdata (wr_entry),
        .rdata (rd_entry),
        .count (rb_count),
        .full  (rb_full),
        .empty (rb_empty)
    );

    always_comb begin
        out_d     = out_q;
        out_d.op  = NOP;
        shooted_d = 1'b0;
        if (bus.flush) begin
            out_d = OUT_RST;
        end else if (deq) begin
            out_d     = rd_entry;
            shooted_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q     <= OUT_RST;
            shooted_q <= 1'b0;
        end else begin
            out_q     <= out_d;
            shooted_q <= shooted_d;
        end
    end

    assign bus.iq_full     = rb_full;
    assign bus.iq_afull    = (rb_count >= CNT_W'(DEPTH - AFULL_MARGIN));
    assign bus.count       = rb_count;
    assign bus.shooted     = shooted_q;
    assign bus.op_out      = out_q.op;
    assign bus.rs1_out     = out_q.rs1;
    assign bus.rs2_out     = out_q.rs2;
    assign bus.rd_out      = out_q.rd;
    assign bus.imm_out     = out_q.imm;
    assign bus.has_imm_out = out_q.has_imm;

endmodule

// File: tb/tb_instr_queue_param.sv
// Directed bench for instr_queue_param: DEPTH=16 and DEPTH=5 instances share one
// stimulus stream, each checked against its own FIFO scoreboard every cycle.
module tb_instr_queue_param;
    import viola_pkg::*;

    localparam int D0 = 16;
    localparam int D1 = 5;
    localparam int AM = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_queue_param_if #(.DEPTH(D0)) i16 ();
    instr_queue_param_if #(.DEPTH(D1)) i5 ();

    instr_queue_param #(.DEPTH(D0), .AFULL_MARGIN(AM)) dut16 (.clk(clk), .rst(rst), .bus(i16.slave));
    instr_queue_param #(.DEPTH(D1), .AFULL_MARGIN(AM)) dut5  (.clk(clk), .rst(rst), .bus(i5.slave));

    assign i5.op       = i16.op;
    assign i5.rs1      = i16.rs1;
    assign i5.rs2      = i16.rs2;
    assign i5.rd       = i16.rd;
    assign i5.imm      = i16.imm;
    assign i5.has_imm  = i16.has_imm;
    assign i5.flush    = i16.flush;
    assign i5.rs_full  = i16.rs_full;
    assign i5.rob_full = i16.rob_full;

    int     total = 0;
    int     bad   = 0;
    instr_t q0[$];
    instr_t q1[$];
    instr_t mout [2];
    bit     mshot [2];
    int     mcnt [2] = '{0, 0};
    instr_t rst_out;
    int     nid = 0;

    function automatic instr_t mk(input int id);
        instr_t t;
        t.op      = 5'(id % 31);
        t.rs1     = 5'(id);
        t.rs2     = 5'(id * 7);
        t.rd      = 5'(id * 3 + 1);
        t.imm     = 32'(id) * 32'h9E37_79B9;
        t.has_imm = id[0];
        return t;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive, take the edge, advance both scoreboards, compare both DUTs.
    task automatic step(input bit v, input instr_t ins, input bit fl,
                        input bit sf, input bit bf, input bit r);
        instr_t o;
        bit     en, de, f, af;
        int     dep, c, s;
        rst          = r;
        i16.op       = v ? ins.op : NOP_OP;
        i16.rs1      = ins.rs1;
        i16.rs2      = ins.rs2;
        i16.rd       = ins.rd;
        i16.imm      = ins.imm;
        i16.has_imm  = ins.has_imm;
        i16.flush    = fl;
        i16.rs_full  = sf;
        i16.rob_full = bf;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            dep = (k == 0) ? D0 : D1;
            en  = v && (mcnt[k] != dep) && !fl && !r;
            de  = (mcnt[k] != 0) && !sf && !bf && !fl && !r;
            if (r || fl) begin
                mout[k]  = rst_out;
                mshot[k] = 1'b0;
                if (k == 0) q0.delete(); else q1.delete();
            end else begin
                if (de) begin
                    if (k == 0) mout[k] = q0.pop_front(); else mout[k] = q1.pop_front();
                    mshot[k] = 1'b1;
                end else begin
                    mout[k].op = NOP_OP;
                    mshot[k]   = 1'b0;
                end
                if (en) begin
                    if (k == 0) q0.push_back(ins); else q1.push_back(ins);
                end
            end
            mcnt[k] = (k == 0) ? q0.size() : q1.size();
            if (k == 0) begin
                o  = {i16.op_out, i16.rs1_out, i16.rs2_out, i16.rd_out, i16.imm_out, i16.has_imm_out};
                s  = int'(i16.shooted); c = int'(i16.count); f = i16.iq_full; af = i16.iq_afull;
            end else begin
                o  = {i5.op_out, i5.rs1_out, i5.rs2_out, i5.rd_out, i5.imm_out, i5.has_imm_out};
                s  = int'(i5.shooted); c = int'(i5.count); f = i5.iq_full; af = i5.iq_afull;
            end
            chk($sformatf("d%0d_shooted", dep), 64'(s), 64'(mshot[k]));
            chk($sformatf("d%0d_out", dep), 64'(o), 64'(mout[k]));
            chk($sformatf("d%0d_count", dep), 64'(c), 64'(mcnt[k]));
            chk($sformatf("d%0d_full", dep), 64'(f), 64'(mcnt[k] == dep));
            chk($sformatf("d%0d_afull", dep), 64'(af), 64'(mcnt[k] >= dep - AM));
        end
    endtask

    task automatic idle(input int n, input bit sf, input bit bf);
        for (int i = 0; i < n; i++) step(1'b0, mk(0), 1'b0, sf, bf, 1'b0);
    endtask

    task automatic push_stalled(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, mk(nid), 1'b0, 1'b1, 1'b0, 1'b0);
            nid++;
        end
    endtask

    initial begin
        int  sent;
        int  guard;
        bit  up;
        rst_out    = '0;
        rst_out.op = NOP_OP;

        // reset, with an op presented that must be dropped
        step(1'b1, mk(40), 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, mk(0), 1'b0, 1'b1, 1'b1, 1'b1);

        // fill 0..15 under rs_full, 17th op offered while full
        push_stalled(16);
        chk("fill_count16", 64'(i16.count), 64'd16);
        chk("fill_full", 64'(i16.iq_full), 64'd1);
        push_stalled(1);

        // drain order
        idle(18, 1'b0, 1'b0);
        chk("drain_empty", 64'(i16.count), 64'd0);

        // wrap: 40 enqueues, count oscillating roughly 3..12
        sent = 0; guard = 0; up = 1'b1;
        while (sent < 40 && guard < 400) begin
            guard++;
            if (up) begin
                step(1'b1, mk(nid), 1'b0, 1'b1, 1'b0, 1'b0);
                nid++; sent++;
                if (mcnt[0] >= 12) up = 1'b0;
            end else begin
                if (guard % 2 == 1) begin
                    step(1'b1, mk(nid), 1'b0, 1'b0, 1'b0, 1'b0);
                    nid++; sent++;
                end else begin
                    step(1'b0, mk(0), 1'b0, 1'b0, 1'b0, 1'b0);
                end
                if (mcnt[0] <= 3) up = 1'b1;
            end
        end
        idle(20, 1'b0, 1'b0);

        // simultaneous enq+deq at count 5, then deq+op while full
        push_stalled(5);
        step(1'b1, mk(nid), 1'b0, 1'b0, 1'b0, 1'b0); nid++;
        chk("simul_count5", 64'(i16.count), 64'd5);
        for (int n = 0; n < 20 && mcnt[0] < 16; n++) push_stalled(1);
        step(1'b1, mk(nid), 1'b0, 1'b0, 1'b0, 1'b0); nid++;
        chk("full_deq_drop", 64'(i16.count), 64'd15);

        // flush at count 9 with op 3 presented
        for (int n = 0; n < 20 && mcnt[0] > 9; n++) idle(1, 1'b0, 1'b0);
        chk("pre_flush_count9", 64'(i16.count), 64'd9);
        step(1'b1, mk(34), 1'b1, 1'b0, 1'b0, 1'b0);
        chk("flush_count0", 64'(i16.count), 64'd0);
        chk("flush_op_nop", 64'(i16.op_out), 64'(NOP_OP));
        idle(4, 1'b0, 1'b0);

        // reset mid-drain
        push_stalled(6);
        idle(2, 1'b0, 1'b0);
        step(1'b1, mk(34), 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_count0", 64'(i16.count), 64'd0);
        idle(3, 1'b0, 1'b0);

        // backpressure: rob_full toggling with 4 queued
        push_stalled(4);
        for (int i = 0; i < 10; i++) idle(1, 1'b0, (i % 2 == 0));
        chk("bp_drained", 64'(q0.size() + q1.size()), 64'd0);
        chk("bp_count0", 64'(i16.count), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
